instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port imem_addr  output  64  fetch address to instruction memory (current fetch_pc).
REQ-005 SHALL have port imem_instr  input  32  instruction word for imem_addr, valid same cycle.
REQ-006 SHALL have port instr_valid  output  1  head entry present.
REQ-007 SHALL have port instr  output  32  head instruction word.
REQ-008 SHALL have port instr_pc  output  64  PC of head instruction.
REQ-009 SHALL have port dec_ready  input  1  downstream accepts head this cycle.
REQ-010 SHALL have port redirect  input  1  branch taken; flush and refetch.
REQ-011 SHALL have port redirect_pc  input  64  new fetch target.
REQ-012 SHALL have port queue_count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-013 SHALL hold internal fetch_pc (64b), FIFO of DEPTH {pc,instr} entries, wr_ptr, rd_ptr, count.
REQ-014 SHALL drive imem_addr = fetch_pc combinationally.
REQ-015 SHALL define pop = instr_valid && dec_ready && !redirect.
REQ-016 SHALL define push = !redirect && (count < DEPTH || pop).
REQ-017 On push: SHALL write {fetch_pc, imem_instr} at wr_ptr, wr_ptr+1 mod DEPTH, fetch_pc <= fetch_pc + 4.
REQ-018 On pop: SHALL advance rd_ptr mod DEPTH.
REQ-019 count SHALL update as count + push - pop; push and pop in the same cycle leave count unchanged.
REQ-020 When full and no pop: SHALL not push; fetch_pc SHALL hold; imem_addr stable.
REQ-021 instr_valid SHALL equal (count != 0); instr and instr_pc SHALL come from the registered entry at rd_ptr, so no combinational path runs from imem_instr to instr.
REQ-022 Fill latency: a word fetched in cycle N SHALL appear at head no earlier than cycle N+1.
REQ-023 On redirect: SHALL set count, wr_ptr and rd_ptr to 0, set fetch_pc <= {redirect_pc[63:2], 2'b00}, and perform no push or pop that cycle, regardless of dec_ready.
REQ-024 Redirect SHALL take priority over all other events, including a simultaneous full condition.
REQ-025 fetch_pc SHALL wrap modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC + 4 -> 0).
REQ-026 With count == 0, dec_ready SHALL have no effect; instr and instr_pc are don't-care.

Reset
REQ-027 While reset is high at a posedge: fetch_pc, count, wr_ptr and rd_ptr SHALL become 0; no push.
REQ-028 Output values after reset: instr_valid=0, queue_count=0, imem_addr=0.
REQ-029 Reset SHALL override redirect, push and pop, and discard all queued entries mid-operation.
REQ-030 First push SHALL occur on the first posedge with reset low, capturing PC 0.

Verification
REQ-031 Reset release, dec_ready=1, memory returns word=addr>>2 -> instr_pc stream 0,4,8,... with instr 0,1,2,...; one valid instr per cycle after the 1-cycle fill.
REQ-032 dec_ready=0 for 10 cycles after reset -> queue_count saturates at 4; imem_addr holds 0x10; head remains pc 0; after dec_ready=1, pcs 0,4,8,0xC,0x10 emerge with no gap or duplicate.
REQ-033 Full queue, redirect=1 with redirect_pc=0x1003 and dec_ready=1 -> next cycle queue_count=0, instr_valid=0, imem_addr=0x1000; the following cycle has head pc 0x1000.
REQ-034 Redirect to 0xFFFF_FFFF_FFFF_FFF8 -> fetched pcs ...FFF8, ...FFFC, 0x0, 0x4.
REQ-035 Reset asserted for 1 cycle with 3 entries queued -> all flushed; outputs per REQ-028; refetch from pc 0.
REQ-036 Random dec_ready/redirect, scoreboard check -> every popped pc is consecutive (+4) from the last redirect target or 0; queue_count never exceeds DEPTH.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: sequential PC fetch into a DEPTH-entry FIFO of {pc, instr}.
// Redirect flushes the queue and restarts fetch at a word-aligned target.
module instr_fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [63:0]              imem_addr,
   input  logic [31:0]              imem_instr,
   output logic                     instr_valid,
   output logic [31:0]              instr,
   output logic [63:0]              instr_pc,
   input  logic                     dec_ready,
   input  logic                     redirect,
   input  logic [63:0]              redirect_pc,
   output logic [$clog2(DEPTH):0]   queue_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [63:0]   fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [63:0]   pc_mem_q    [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];

   logic full;
   logic push;
   logic pop;

   assign full  = (count_q == CW'(DEPTH));
   assign pop   = instr_valid && dec_ready && !redirect;
   assign push  = !redirect && (!full || pop);

   assign imem_addr   = fetch_pc_q;
   assign instr_valid = (count_q != '0);
   assign instr       = instr_mem_q[rd_ptr_q];
   assign instr_pc    = pc_mem_q[rd_ptr_q];
   assign queue_count = count_q;

   // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (redirect) begin
         fetch_pc_d = {redirect_pc[63:2], 2'b00};
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
            wr_ptr_d   = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // NOTE: entry storage is not reset; count_q gates visibility, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_instr;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed and scoreboarded checks for instr_fetch_queue; memory returns word = addr >> 2.
module tb_instr_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        instr_valid;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        dec_ready;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic [2:0]  queue_count;

   int n_checks;
   int n_pass;

   instr_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_addr   (imem_addr),
      .imem_instr  (imem_instr),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .dec_ready   (dec_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .queue_count (queue_count)
   );

   assign imem_instr = 32'(imem_addr >> 2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Inputs change and outputs are sampled on the falling edge; one call spans one posedge.
   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      logic [63:0] exp_pc;
      logic [63:0] pcs [4];
      logic [31:0] ins [4];
      int          exp_cnt;
      logic        m_pop;
      logic        m_push;

      n_checks    = 0;
      n_pass      = 0;
      reset       = 1'b1;
      dec_ready   = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      tick();
      tick();

      // Reset state
      check("rst_valid", 64'(instr_valid), 64'd0);
      check("rst_count", 64'(queue_count), 64'd0);
      check("rst_addr",  imem_addr,        64'd0);

      // Streaming with dec_ready=1: one instruction per cycle after 1-cycle fill
      reset     = 1'b0;
      dec_ready = 1'b1;
      tick();
      for (int k = 0; k < 6; k++) begin
         check("stream_valid", 64'(instr_valid), 64'd1);
         check("stream_pc",    instr_pc,         64'(4 * k));
         check("stream_instr", 64'(instr),       64'(k));
         check("stream_count", 64'(queue_count), 64'd1);
         tick();
      end

      // Backpressure: fill to DEPTH, fetch PC stalls at 0x10, then drain in order
      reset     = 1'b1;
      dec_ready = 1'b0;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      check("full_count", 64'(queue_count), 64'd4);
      check("full_addr",  imem_addr,        64'h10);
      check("full_head",  instr_pc,         64'h0);
      dec_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("drain_pc", instr_pc, 64'(4 * k));
         tick();
      end

      // Redirect while full with dec_ready=1: flush, aligned refetch
      dec_ready = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      check("pre_redir_count", 64'(queue_count), 64'd4);
      redirect    = 1'b1;
      redirect_pc = 64'h1003;
      dec_ready   = 1'b1;
      tick();
      redirect = 1'b0;
      check("redir_count", 64'(queue_count), 64'd0);
      check("redir_valid", 64'(instr_valid), 64'd0);
      check("redir_addr",  imem_addr,        64'h1000);
      tick();
      check("redir_head_valid", 64'(instr_valid), 64'd1);
      check("redir_head_pc",    instr_pc,         64'h1000);
      check("redir_head_instr", 64'(instr),       64'h400);

      // Fetch PC wraps modulo 2^64
      pcs[0] = 64'hFFFF_FFFF_FFFF_FFF8; ins[0] = 32'hFFFF_FFFE;
      pcs[1] = 64'hFFFF_FFFF_FFFF_FFFC; ins[1] = 32'hFFFF_FFFF;
      pcs[2] = 64'h0;                   ins[2] = 32'h0;
      pcs[3] = 64'h4;                   ins[3] = 32'h1;
      redirect    = 1'b1;
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      tick();
      redirect = 1'b0;
      check("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
      tick();
      for (int k = 0; k < 4; k++) begin
         check("wrap_pc",    instr_pc,   pcs[k]);
         check("wrap_instr", 64'(instr), 64'(ins[k]));
         tick();
      end

      // Reset mid-operation with 3 entries queued (and a competing redirect)
      dec_ready   = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 64'h200;
      tick();
      redirect = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      check("pre_rst_count", 64'(queue_count), 64'd3);
      reset       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 64'h500;
      tick();
      reset    = 1'b0;
      redirect = 1'b0;
      check("mid_rst_valid", 64'(instr_valid), 64'd0);
      check("mid_rst_count", 64'(queue_count), 64'd0);
      check("mid_rst_addr",  imem_addr,        64'd0);
      tick();
      check("post_rst_valid", 64'(instr_valid), 64'd1);
      check("post_rst_pc",    instr_pc,         64'd0);
      check("post_rst_count", 64'(queue_count), 64'd1);

      // Random dec_ready/redirect against an in-order PC and occupancy model
      exp_pc  = 64'd0;
      exp_cnt = 1;
      for (int k = 0; k < 300; k++) begin
         dec_ready = 1'($urandom_range(0, 1));
         redirect  = ($urandom_range(0, 11) == 0);
         redirect_pc = {$urandom, $urandom};
         #1;
         check("rnd_count", 64'(queue_count), 64'(exp_cnt));
         check("rnd_count_le_depth", 64'(queue_count <= 3'(DEPTH)), 64'd1);
         m_pop  = (exp_cnt != 0) && dec_ready && !redirect;
         m_push = !redirect && (exp_cnt < DEPTH || m_pop);
         if (m_pop) begin
            check("rnd_pop_pc",    instr_pc,   exp_pc);
            check("rnd_pop_instr", 64'(instr), 64'(32'(exp_pc >> 2)));
            exp_pc = exp_pc + 64'd4;
         end
         if (redirect) begin
            exp_pc  = {redirect_pc[63:2], 2'b00};
            exp_cnt = 0;
         end else begin
            exp_cnt = exp_cnt + int'(m_push) - int'(m_pop);
         end
         tick();
      end
      redirect  = 1'b0;
      dec_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
